// File: rtl/sym_err_checker.sv
// sym_err_checker: compares delayed LFSR reference symbols with receiver decisions over one LFSR period.
// Define SYM_ERR_BIT_COUNT_EN to also count bit errors (popcount of the symbol difference).
module sym_err_checker #(
    parameter int SYM_W = 4,
    parameter int DELAY = 8,
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             clear,
    input  logic [SYM_W-1:0] ref_sym,
    input  logic [SYM_W-1:0] rx_sym,
    input  logic             cycle_pulse,
    output logic [CNT_W-1:0] sym_cnt,
    output logic [CNT_W-1:0] sym_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             result_valid,
    output logic             locked,
    output logic             ovf
);
    typedef enum logic [1:0] {FILL, WAIT_SYNC, COUNT} state_t;

    state_t           state_q, state_d;
    logic [5:0]       fill_q, fill_d;
    logic [CNT_W-1:0] run_sym_q, run_sym_d, run_err_q, run_err_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d, sym_err_cnt_q, sym_err_cnt_d;
    logic             sticky_q, sticky_d, ovf_q, ovf_d, rv_q, rv_d;
    logic [SYM_W-1:0] ref_d;
    logic             err, bnd, restart, acc, bit_ovf;

    generate
        if (DELAY == 0) begin : g_nodly
            assign ref_d = ref_sym;
        end else begin : g_dly
            logic [SYM_W-1:0] line_q [DELAY];
            logic [SYM_W-1:0] line_d [DELAY];
            always_comb begin
                line_d = line_q;
                if (clk_en) begin
                    line_d[0] = ref_sym;
                    for (int k = 1; k < DELAY; k++) line_d[k] = line_q[k-1];
                end
                if (clear) line_d = '{default: '0};
            end
            always_ff @(posedge clk or posedge reset) begin
                if (reset) line_q <= '{default: '0};
                else line_q <= line_d;
            end
            assign ref_d = line_q[DELAY-1];
        end
    endgenerate

    // restart covers both the sync sample (WAIT_SYNC) and every later boundary (COUNT)
    assign err     = ref_d != rx_sym;
    assign bnd     = clk_en && cycle_pulse && state_q == COUNT;
    assign restart = clk_en && cycle_pulse && state_q != FILL;
    assign acc     = clk_en && !cycle_pulse && state_q == COUNT;

`ifdef SYM_ERR_BIT_COUNT_EN
    localparam int POP_W = $clog2(SYM_W + 1);
    logic [POP_W-1:0] pop;
    logic [CNT_W:0]   bit_sum;
    logic [CNT_W-1:0] run_bit_q, run_bit_d, bit_cnt_q, bit_cnt_d;

    always_comb begin
        pop = '0;
        for (int k = 0; k < SYM_W; k++) pop = pop + POP_W'(ref_d[k] ^ rx_sym[k]);
        bit_sum   = {1'b0, run_bit_q} + {{(CNT_W + 1 - POP_W){1'b0}}, pop};
        bit_ovf   = acc && bit_sum[CNT_W];
        run_bit_d = restart ? CNT_W'(pop) : acc ? (bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0]) : run_bit_q;
        bit_cnt_d = bnd ? run_bit_q : bit_cnt_q;
        if (clear) begin
            run_bit_d = '0;
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_bit_q <= '0;
            bit_cnt_q <= '0;
        end else begin
            run_bit_q <= run_bit_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_err_cnt = bit_cnt_q;
`else
    assign bit_ovf     = 1'b0;
    assign bit_err_cnt = '0;
`endif

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        case (state_q)
            FILL: begin
                if (DELAY == 0 || (clk_en && fill_q == 6'(DELAY - 1))) state_d = WAIT_SYNC;
                else if (clk_en) fill_d = fill_q + 6'd1;
            end
            WAIT_SYNC: if (clk_en && cycle_pulse) state_d = COUNT;
            default: ;
        endcase
        run_sym_d     = restart ? CNT_W'(1) : (acc && !(&run_sym_q)) ? run_sym_q + CNT_W'(1) : run_sym_q;
        run_err_d     = restart ? CNT_W'(err) : (acc && err && !(&run_err_q)) ? run_err_q + CNT_W'(1) : run_err_q;
        sticky_d      = !restart && (sticky_q || (acc && &run_sym_q) || (acc && err && &run_err_q) || bit_ovf);
        sym_cnt_d     = bnd ? run_sym_q : sym_cnt_q;
        sym_err_cnt_d = bnd ? run_err_q : sym_err_cnt_q;
        ovf_d         = bnd ? sticky_q : ovf_q;
        rv_d          = bnd;
        // clear wins over a coincident boundary, so no result is issued
        if (clear) begin
            state_d       = FILL;
            fill_d        = '0;
            run_sym_d     = '0;
            run_err_d     = '0;
            sticky_d      = 1'b0;
            sym_cnt_d     = '0;
            sym_err_cnt_d = '0;
            ovf_d         = 1'b0;
            rv_d          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            fill_q        <= '0;
            run_sym_q     <= '0;
            run_err_q     <= '0;
            sticky_q      <= 1'b0;
            sym_cnt_q     <= '0;
            sym_err_cnt_q <= '0;
            ovf_q         <= 1'b0;
            rv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_q        <= fill_d;
            run_sym_q     <= run_sym_d;
            run_err_q     <= run_err_d;
            sticky_q      <= sticky_d;
            sym_cnt_q     <= sym_cnt_d;
            sym_err_cnt_q <= sym_err_cnt_d;
            ovf_q         <= ovf_d;
            rv_q          <= rv_d;
        end
    end

    assign sym_cnt      = sym_cnt_q;
    assign sym_err_cnt  = sym_err_cnt_q;
    assign ovf          = ovf_q;
    assign result_valid = rv_q;
    assign locked       = state_q == COUNT;
endmodule

// File: tb/tb_sym_err_checker.sv
// tb_sym_err_checker: two instances (DELAY=8/CNT_W=24 and DELAY=0/CNT_W=4) checked every cycle
// against a window-level reference model, plus literal expectations for the directed scenarios.
module tb_sym_err_checker;
    localparam int DLY [2] = '{8, 0};
    localparam int MX  [2] = '{(1 << 24) - 1, 15};
`ifdef SYM_ERR_BIT_COUNT_EN
    localparam bit BITS = 1'b1;
`else
    localparam bit BITS = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b1;
    logic        en [2], clr [2], pls [2];
    logic [3:0]  rs [2], rx [2];
    logic [23:0] sc0, se0, be0;
    logic [3:0]  sc1, se1, be1;
    logic        rv [2], lk [2], ov [2];

    sym_err_checker #(.SYM_W(4), .DELAY(8), .CNT_W(24)) u0 (
        .clk(clk), .reset(reset), .clk_en(en[0]), .clear(clr[0]), .ref_sym(rs[0]), .rx_sym(rx[0]),
        .cycle_pulse(pls[0]), .sym_cnt(sc0), .sym_err_cnt(se0), .bit_err_cnt(be0),
        .result_valid(rv[0]), .locked(lk[0]), .ovf(ov[0]));
    sym_err_checker #(.SYM_W(4), .DELAY(0), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .clk_en(en[1]), .clear(clr[1]), .ref_sym(rs[1]), .rx_sym(rx[1]),
        .cycle_pulse(pls[1]), .sym_cnt(sc1), .sym_err_cnt(se1), .bit_err_cnt(be1),
        .result_valid(rv[1]), .locked(lk[1]), .ovf(ov[1]));

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    bit go = 1'b0;

    // reference model state: sample history, window totals, sync flag
    logic [3:0] hbuf [2][64];
    int  hcnt [2], m_nen [2], m_nclk [2], m_sym [2], m_err [2], m_bit [2];
    bit  m_st [2], m_sync [2];
    int  e_sc [2], e_se [2], e_be [2];
    bit  e_ov [2], e_rv [2];

    // stimulus configuration
    int  enm [2], em [2], per [2], pcnt [2], dclk [2], inj0 [2], inja [2];
    bit  rclr [2], rbnd [2];
    int  rvn [2], r_sc [2], r_se [2], r_be [2], r_ov [2];
    int  a_sc [2], a_se [2], a_be [2];
    logic [3:0] gd;

    task automatic chk(input string nm, input int i, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[u%0d]: got %0d, expected %0d at %0t", nm, i, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] refd(input int i);
        if (DLY[i] == 0) return rs[i];
        return hcnt[i] >= DLY[i] ? hbuf[i][(hcnt[i] - DLY[i]) % 64] : 4'd0;
    endfunction

    function automatic void mreset(input int i);
        hcnt[i] = 0; m_nen[i] = 0; m_nclk[i] = 0;
        m_sym[i] = 0; m_err[i] = 0; m_bit[i] = 0; m_st[i] = 0; m_sync[i] = 0;
        e_sc[i] = 0; e_se[i] = 0; e_be[i] = 0; e_ov[i] = 0; e_rv[i] = 0;
    endfunction

    function automatic void mstep(input int i);
        logic [3:0] d;
        bit e, elig;
        int b;
        e_rv[i] = 0;
        elig = DLY[i] == 0 ? m_nclk[i] >= 1 : m_nen[i] >= DLY[i];
        m_nclk[i]++;
        if (!en[i]) return;
        d = refd(i);
        e = d != rx[i];
        b = BITS ? $countones(d ^ rx[i]) : 0;
        if (pls[i] && (m_sync[i] || elig)) begin
            if (m_sync[i]) begin
                e_sc[i] = m_sym[i]; e_se[i] = m_err[i]; e_be[i] = m_bit[i]; e_ov[i] = m_st[i]; e_rv[i] = 1;
            end
            m_sync[i] = 1; m_sym[i] = 1; m_err[i] = int'(e); m_bit[i] = b; m_st[i] = 0;
        end else if (m_sync[i]) begin
            if (m_sym[i] == MX[i]) m_st[i] = 1; else m_sym[i]++;
            if (e) begin
                if (m_err[i] == MX[i]) m_st[i] = 1; else m_err[i]++;
            end
            if (m_bit[i] + b > MX[i]) begin m_bit[i] = MX[i]; m_st[i] = 1; end
            else m_bit[i] += b;
        end
        hbuf[i][hcnt[i] % 64] = rs[i];
        hcnt[i]++;
        m_nen[i]++;
    endfunction

    always @(posedge clk or posedge reset)
        for (int i = 0; i < 2; i++) begin
            if (reset || clr[i]) mreset(i);
            else mstep(i);
        end

    // compare against the model, then drive the next inputs
    always @(negedge clk) begin
        a_sc[0] = int'(sc0); a_se[0] = int'(se0); a_be[0] = int'(be0);
        a_sc[1] = int'(sc1); a_se[1] = int'(se1); a_be[1] = int'(be1);
        for (int i = 0; i < 2; i++) begin
            if (go) begin
                chk("sym_cnt", i, a_sc[i], e_sc[i]);
                chk("sym_err_cnt", i, a_se[i], e_se[i]);
                chk("bit_err_cnt", i, a_be[i], e_be[i]);
                chk("ovf", i, int'(ov[i]), int'(e_ov[i]));
                chk("result_valid", i, int'(rv[i]), int'(e_rv[i]));
                chk("locked", i, int'(lk[i]), int'(m_sync[i]));
                if (rv[i]) begin
                    rvn[i]++; r_sc[i] = a_sc[i]; r_se[i] = a_se[i]; r_be[i] = a_be[i]; r_ov[i] = int'(ov[i]);
                end
            end
            dclk[i]++;
            clr[i] = 1'b0;
            case (enm[i])
                0: en[i] = 1'b1;
                1: en[i] = dclk[i] % 3 == 0;
                2: en[i] = $urandom_range(0, 3) != 0;
                default: en[i] = 1'b0;
            endcase
            rs[i] = 4'($urandom_range(0, 15));
            if (en[i]) begin
                pls[i] = pcnt[i] % per[i] == 0;
                pcnt[i]++;
            end else pls[i] = 1'($urandom_range(0, 1));
            if (rclr[i]) begin
                clr[i] = 1'b1;
                rclr[i] = 0;
                if (rbnd[i]) begin en[i] = 1'b1; pls[i] = 1'b1; rbnd[i] = 0; end
            end
            gd = refd(i);
            case (em[i])
                1: rx[i] = ~gd;
                2: rx[i] = $urandom_range(0, 7) == 0 ? gd ^ 4'($urandom_range(1, 15)) : gd;
                default: rx[i] = gd;
            endcase
            if (en[i] && !pls[i] && inj0[i] > 0) begin rx[i] = gd ^ 4'b0001; inj0[i]--; end
            if (en[i] && !pls[i] && inja[i] > 0) begin rx[i] = ~gd; inja[i]--; end
        end
    end

    task automatic wait_rv(input int i);
        int start = rvn[i];
        int k = 0;
        while (rvn[i] == start && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (rvn[i] == start) chk("rv_timeout", i, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            en[i] = 0; clr[i] = 0; pls[i] = 0; rs[i] = 0; rx[i] = 0;
            em[i] = 0; pcnt[i] = 0; dclk[i] = 0; inj0[i] = 0; inja[i] = 0;
            rclr[i] = 0; rbnd[i] = 0; rvn[i] = 0;
            mreset(i);
        end
        enm[0] = 0; per[0] = 15;
        enm[1] = 3; per[1] = 20; em[1] = 1;
        @(posedge clk);
        #1 go = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sym_cnt", 0, int'(sc0), 0);
        chk("rst_locked", 0, int'(lk[0]), 0);
        chk("rst_rv", 1, int'(rv[1]), 0);
        chk("rst_ovf", 1, int'(ov[1]), 0);
        reset = 1'b0;

        // clean stream, 15-sample windows
        repeat (2) begin
            wait_rv(0);
            chk("clean_sym", 0, r_sc[0], 15);
            chk("clean_err", 0, r_se[0], 0);
            chk("clean_ovf", 0, r_ov[0], 0);
            chk("clean_locked", 0, int'(lk[0]), 1);
        end
        inj0[0] = 3;
        wait_rv(0);
        chk("inj3_sym", 0, r_sc[0], 15);
        chk("inj3_err", 0, r_se[0], 3);
        chk("inj3_bit", 0, r_be[0], BITS ? 3 : 0);
        wait_rv(0);
        chk("after_inj_err", 0, r_se[0], 0);
        inja[0] = 1;
        wait_rv(0);
        chk("inv_err", 0, r_se[0], 1);
        chk("inv_bit", 0, r_be[0], BITS ? 4 : 0);

        // back-to-back pulses
        per[0] = 1;
        wait_rv(0);
        wait_rv(0);
        chk("pulse1_sym", 0, r_sc[0], 1);
        per[0] = 15;
        wait_rv(0);

        // clear mid-window, then resync
        repeat (5) @(posedge clk);
        rclr[0] = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("clr_locked", 0, int'(lk[0]), 0);
        chk("clr_sym", 0, int'(sc0), 0);
        chk("clr_ovf", 0, int'(ov[0]), 0);
        wait_rv(0);
        chk("resync_sym", 0, r_sc[0], 15);

        // clear coincident with a boundary sample
        rclr[0] = 1; rbnd[0] = 1;
        @(posedge clk);
        @(negedge clk);
        chk("clr_bnd_rv", 0, int'(rv[0]), 0);
        chk("clr_bnd_locked", 0, int'(lk[0]), 0);
        chk("clr_bnd_sym", 0, int'(sc0), 0);

        // narrow counters: every third clock enabled, all-wrong 20-sample window
        @(posedge clk);
        enm[0] = 2; em[0] = 2;
        enm[1] = 1; per[1] = 20; em[1] = 1; pcnt[1] = 0;
        wait_rv(1);
        chk("sat_sym", 1, r_sc[1], 15);
        chk("sat_err", 1, r_se[1], 15);
        chk("sat_ovf", 1, r_ov[1], 1);
        chk("sat_locked", 1, int'(lk[1]), 1);
        per[1] = 10; pcnt[1] = 1; em[1] = 0;
        wait_rv(1);
        chk("post_sat_sym", 1, r_sc[1], 10);
        chk("post_sat_err", 1, r_se[1], 1);
        chk("post_sat_ovf", 1, r_ov[1], 0);

        // randomized windows, clears and one mid-run reset
        for (int s = 0; s < 20; s++) begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                enm[i] = 2; em[i] = 2; per[i] = $urandom_range(1, 25);
            end
            if ($urandom_range(0, 3) == 0) begin
                int j = $urandom_range(0, 1);
                rclr[j] = 1;
                rbnd[j] = 1'($urandom_range(0, 1));
            end
            if (s == 10) begin
                #2 reset = 1'b1;
                @(posedge clk);
                #2 reset = 1'b0;
            end
            repeat (150) @(posedge clk);
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sym_err_checker.md
Name: sym_err_checker

Overview:
- Downstream consumer of the maximal-length LFSR symbol generator.
- Compares the generator's 4-bit reference symbols, delayed by a fixed channel/receiver latency, against the receiver's sliced symbol decisions.
- Accumulates symbol-error and symbol counts over one full LFSR period, framed by the generator's periodic cycle pulse.
- Latches per-period totals for readout by test logic or the signal tap.

Parameters:
- SYM_W, 4, symbol width in bits; must match the generator symbol output.
- DELAY, 8, reference delay in clk_en samples; legal range 0..63; 0 means no delay.
- CNT_W, 24, width of all counters; must be at least the LFSR length + 1.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- clk_en  in  1  symbol-rate enable; all data advances only when high
- clear  in  1  synchronous restart, clk-qualified and not gated by clk_en
- ref_sym  in  SYM_W  reference symbol from the LFSR generator
- rx_sym  in  SYM_W  receiver decision, sampled in the same clk_en as ref_sym
- cycle_pulse  in  1  LFSR period boundary; valid only when clk_en is high
- sym_cnt  out  CNT_W  symbols compared in the last completed window
- sym_err_cnt  out  CNT_W  symbol errors in the last completed window
- bit_err_cnt  out  CNT_W  bit errors in the last completed window; 0 when the feature is off
- result_valid  out  1  one-clk pulse when the outputs update
- locked  out  1  high while in COUNT state
- ovf  out  1  some counter saturated in the last completed window

Behaviour:
- Reset: state=FILL; delay line, running counters and all outputs are 0.
- Delay line:
  - DELAY-stage shift register of ref_sym, advancing only on clk_en.
  - ref_d is the ref_sym from exactly DELAY clk_en samples earlier.
  - If DELAY=0, ref_d=ref_sym combinationally.
- FILL state:
  - A fill counter increments per clk_en.
  - Move to WAIT_SYNC on the clk_en on which the count reaches DELAY.
  - If DELAY=0, go to WAIT_SYNC on the first clk after reset or clear.
- WAIT_SYNC state:
  - No counting.
  - On clk_en with cycle_pulse=1, go to COUNT. This sample is the first sample of window 1.
- COUNT state, each clk_en:
  - err = (ref_d != rx_sym).
  - Running symbol count += 1; running symbol-error count += err.
- Window boundary (clk_en with cycle_pulse=1 while already in COUNT):
  - Output registers load the running totals accumulated before this sample.
  - ovf loads the sticky saturation flag.
  - result_valid=1 on the next clk edge, for exactly one clk.
  - Running counters restart as if this sample were the first sample of the new window: symbol count=1, error count=err.
  - The sticky saturation flag clears.
- Latency: outputs and result_valid are registered and appear one clk after the boundary sample.
- Outputs hold their values between boundaries; result_valid=0 otherwise.
- Saturation: running counters stop at all-ones and never wrap. The sticky flag sets on any attempted increment past all-ones.
- Boundary cases:
  - clk_en=0: cycle_pulse is ignored and nothing changes.
  - clear=1: same effect as reset, applied synchronously. It overrides a simultaneous boundary, so no result_valid is issued.
  - Reset mid-window: the partial window is discarded.
  - Two pulses on consecutive clk_en samples: produce a window with sym_cnt=1.
- locked=1 exactly when state=COUNT. COUNT is left only by reset or clear.

Optional Feature:
- Macro: SYM_ERR_BIT_COUNT_EN.
- Defined:
  - Bit error = popcount(ref_d ^ rx_sym), range 0..SYM_W.
  - Accumulated in a saturating running bit-error counter with the same window, latch and ovf rules.
  - bit_err_cnt reports the latched value.
- Undefined:
  - No popcount logic or counter is built.
  - bit_err_cnt is tied to 0.
  - ovf reflects only the symbol counters.

Test Plan:
- DELAY=8, rx_sym = ref_sym delayed 8 clk_en samples, pulse every 15 samples:
  - locked rises after the first pulse.
  - Each result_valid shows sym_cnt=15, sym_err_cnt=0, ovf=0.
- Same setup, rx_sym bit 0 inverted on 3 samples of one window:
  - That window shows sym_err_cnt=3; bit_err_cnt=3 if the feature is on.
  - The next window returns to 0.
- DELAY=0, clk_en high every 3rd clk:
  - Counts advance only on enabled clocks.
  - A cycle_pulse asserted with clk_en=0 causes no result_valid.
- CNT_W=4, all symbols wrong, window length 20:
  - sym_cnt=15, sym_err_cnt=15, ovf=1.
  - Next 10-sample clean window shows ovf=0.
- clear asserted mid-window, and also on a boundary sample:
  - No result_valid.
  - Outputs are 0, locked=0.
  - FILL takes DELAY enabled samples before WAIT_SYNC.
- Feature on, rx_sym=~ref_d for one sample in a 15-sample window:
  - sym_err_cnt=1, bit_err_cnt=4.
